alu_issue: RTL and testbench
============================

# alu_issue

Execute-issue stage sitting directly upstream of the 32-bit ALU. It accepts one decoded instruction per cycle from decode through a valid/ready handshake, resolves operands (regfile value, writeback bypass, or forwarding of the ALU's registered result `R`), sign-extends immediates, and drives the ALU's `A`, `B` and `ALUControl`. The ALU registers `R` one edge after `A/B/ALUControl` are presented, and this block's forwarding logic is built around that one-cycle latency.

## Interface
- No parameters; data width is fixed at 32, register index width at 5.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `in_valid` in 1 / `in_ready` out 1: decode handshake. A transfer occurs on an edge where both are 1.
- `in_op` in 3: 000 ADD, 001 SUB, 010 XOR, 011 ADDI, 100 XORI; 101–111 illegal.
- `in_rs`, `in_rt`, `in_rd` in 5: source and destination register indices.
- `in_rs_val`, `in_rt_val` in 32: regfile read data.
- `in_imm` in 16: immediate.
- `wb_valid` in 1, `wb_rd` in 5, `wb_data` in 32: writeback bypass source.
- `alu_R` in 32: the ALU's registered result `R`.
- `stall` in 1: downstream hold request.
- `A`, `B` out 32: ALU operands.
- `ALUControl` out 3: 000 add, 001 sub, 010 xor, 111 bubble/illegal (the ALU outputs 0).
- `ex_valid` out 1: the issue register holds an instruction.
- `ex_rd` out 5: destination of the held instruction.
- `illegal` out 1: the held instruction has an illegal opcode.

## Operation
- `in_ready = !(ex_valid && stall)`. This is combinational.
- **Capture edge** (`in_valid && in_ready`):
  - Latch the operation and `rd`, and set `ex_valid` to 1.
  - `ALUControl`: ADD and ADDI give 000, SUB gives 001, XOR and XORI give 010, illegal gives 111.
  - For an illegal op, set `illegal` to 1 and force `ex_rd` to 0.
- **Operand A resolution**, first match wins:
  1. `in_rs == 0` gives 0.
  2. `ex_valid && ex_rd == in_rs` (the instruction being consumed by the ALU this edge) sets `fwdA = 1`.
  3. `wb_valid && wb_rd == in_rs` gives `wb_data`.
  4. Otherwise `in_rs_val`.
- **Operand B resolution**:
  - For ADDI and XORI, B is `{{16{in_imm[15]}}, in_imm}` and is never forwarded.
  - Otherwise B follows the same four-step rule as A, applied to `in_rt` and `fwdB`.
- **Output mux**: `A = fwdA ? alu_R : opA_q` and `B = fwdB ? alu_R : opB_q`. This is combinational.
- **Hold edge** (`ex_valid && stall`):
  - Latch `opA_q <= A` and `opB_q <= B`, then clear `fwdA` and `fwdB`.
  - The forwarded value is therefore frozen before the ALU overwrites `R`.
  - Operation and `rd` are unchanged.
- **Drain edge** (`!stall`, no transfer): set `ex_valid` to 0.
- **Bubble** (`ex_valid == 0`):
  - `ALUControl` is 111, `A` and `B` are 0, `ex_rd` is 0, `illegal` is 0.
  - Forwarding into the next instruction is disabled.
- **Register 0** is never forwarded or bypassed.

## Timing
- Reset values: `ex_valid=0`, `ex_rd=0`, `illegal=0`, `ALUControl=111`, `A=0`, `B=0`, `fwdA=fwdB=0`, `in_ready=1`.
- Reset asserted mid-stall drops the held instruction with no partial update.
- Latency:
  - Decode transfer at edge n puts the operands on `A/B` during cycle n+1.
  - The ALU result appears on `alu_R` during cycle n+2.
- Back-to-back dependent instructions issue with zero stall cycles.
- Throughput is one instruction per cycle when `stall=0`.
- Simultaneous rules:
  - A forward match beats a writeback match for the same register.
  - `stall` asserted while `ex_valid=0` has no effect, and `in_ready` stays 1.
- `stall` held for k cycles keeps `A/B/ALUControl` constant for all k+1 cycles, independent of `alu_R`.

## Test plan
- **Reset mid-operation.** Hold `stall=1` with `ex_valid=1`, then pull `reset` low between edges. Immediately `ex_valid=0`, `ALUControl=111`, `A=B=0`, `in_ready=1`.
- **Forwarding.** Issue ADD r3 = r1 (5) + r2 (7), then SUB r4 = r3 − r1 with `in_rs_val=99` (stale). When `alu_R=12`, expect `A=12`, `B=5`, `ALUControl=001`.
- **Stall with forwarding.** Repeat the previous case with `stall=1` for 2 cycles during SUB. `A` stays 12 after `alu_R` changes to 7, and `in_ready=0` for both cycles.
- **Immediate.** ADDI with `rs=1` (value 10) and `imm=0xFFFC` gives `A=10`, `B=0xFFFFFFFC`, `ALUControl=000`, and no forwarding on B.
- **r0 and writeback bypass.** Hold `ex_rd=0`, then issue XOR with `rs=0` (`in_rs_val=0xDEAD`), `rt=6`, and `wb_valid=1`, `wb_rd=6`, `wb_data=0x55`. Expect `A=0`, `B=0x55`.
- **Illegal op.** Issue `in_op=110`, then ADD reading its `rd`. Expect `illegal=1`, `ALUControl=111`, `ex_rd=0`; the following ADD takes `in_rs_val`, not `alu_R`.

Source files
------------

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : Execute-issue stage feeding a 32-bit ALU with a registered
//            result; resolves operands with bypass and R-forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  input  logic [15:0] in_imm,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [31:0] alu_R,
  input  logic        stall,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  ALUControl,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        illegal
);

  localparam logic [2:0] c_OP_ADD   = 3'b000;
  localparam logic [2:0] c_OP_SUB   = 3'b001;
  localparam logic [2:0] c_OP_XOR   = 3'b010;
  localparam logic [2:0] c_OP_ADDI  = 3'b011;
  localparam logic [2:0] c_OP_XORI  = 3'b100;
  localparam logic [2:0] c_CTL_ADD  = 3'b000;
  localparam logic [2:0] c_CTL_SUB  = 3'b001;
  localparam logic [2:0] c_CTL_XOR  = 3'b010;
  localparam logic [2:0] c_CTL_NOP  = 3'b111;

  logic        r_ex_valid;
  logic [2:0]  r_ctrl;
  logic [4:0]  r_ex_rd;
  logic        r_illegal;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic        r_fwdA;
  logic        r_fwdB;

  logic        w_xfer;
  logic        w_hold;
  logic        w_ill;
  logic        w_imm_op;
  logic [2:0]  w_ctrl;
  logic [31:0] w_opA;
  logic [31:0] w_opB;
  logic        w_fwdA;
  logic        w_fwdB;

  assign in_ready = !(r_ex_valid && stall);
  assign w_xfer   = in_valid && in_ready;
  assign w_hold   = r_ex_valid && stall;

  always_comb begin
    w_ctrl   = c_CTL_NOP;
    w_ill    = 1'b0;
    w_imm_op = 1'b0;
    case (in_op)
      c_OP_ADD:  w_ctrl = c_CTL_ADD;
      c_OP_SUB:  w_ctrl = c_CTL_SUB;
      c_OP_XOR:  w_ctrl = c_CTL_XOR;
      c_OP_ADDI: begin w_ctrl = c_CTL_ADD; w_imm_op = 1'b1; end
      c_OP_XORI: begin w_ctrl = c_CTL_XOR; w_imm_op = 1'b1; end
      default:   w_ill = 1'b1;
    endcase
  end

  // Operand priority: r0, in-flight result (taken from R next cycle), writeback, regfile.
  always_comb begin
    w_opA  = in_rs_val;
    w_fwdA = 1'b0;
    if (in_rs == 5'd0) begin
      w_opA = 32'd0;
    end else if (r_ex_valid && (r_ex_rd == in_rs)) begin
      w_opA  = 32'd0;
      w_fwdA = 1'b1;
    end else if (wb_valid && (wb_rd == in_rs)) begin
      w_opA = wb_data;
    end

    w_opB  = in_rt_val;
    w_fwdB = 1'b0;
    if (w_imm_op) begin
      w_opB = {{16{in_imm[15]}}, in_imm};
    end else if (in_rt == 5'd0) begin
      w_opB = 32'd0;
    end else if (r_ex_valid && (r_ex_rd == in_rt)) begin
      w_opB  = 32'd0;
      w_fwdB = 1'b1;
    end else if (wb_valid && (wb_rd == in_rt)) begin
      w_opB = wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_valid <= 1'b0;
      r_ctrl     <= c_CTL_NOP;
      r_ex_rd    <= 5'd0;
      r_illegal  <= 1'b0;
      r_opA      <= 32'd0;
      r_opB      <= 32'd0;
      r_fwdA     <= 1'b0;
      r_fwdB     <= 1'b0;
    end else if (w_xfer) begin
      r_ex_valid <= 1'b1;
      r_ctrl     <= w_ctrl;
      r_ex_rd    <= w_ill ? 5'd0 : in_rd;
      r_illegal  <= w_ill;
      r_opA      <= w_opA;
      r_opB      <= w_opB;
      r_fwdA     <= w_fwdA;
      r_fwdB     <= w_fwdB;
    end else if (w_hold) begin
      // Freeze the forwarded value before the ALU overwrites R.
      r_opA  <= A;
      r_opB  <= B;
      r_fwdA <= 1'b0;
      r_fwdB <= 1'b0;
    end else if (!stall) begin
      r_ex_valid <= 1'b0;
      r_ctrl     <= c_CTL_NOP;
      r_ex_rd    <= 5'd0;
      r_illegal  <= 1'b0;
      r_opA      <= 32'd0;
      r_opB      <= 32'd0;
      r_fwdA     <= 1'b0;
      r_fwdB     <= 1'b0;
    end
  end

  assign A          = !r_ex_valid ? 32'd0 : (r_fwdA ? alu_R : r_opA);
  assign B          = !r_ex_valid ? 32'd0 : (r_fwdB ? alu_R : r_opB);
  assign ALUControl = r_ex_valid ? r_ctrl : c_CTL_NOP;
  assign ex_valid   = r_ex_valid;
  assign ex_rd      = r_ex_valid ? r_ex_rd : 5'd0;
  assign illegal    = r_ex_valid && r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Directed and randomized checks of alu_issue against a reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_rs_val, in_rt_val;
  logic [15:0] in_imm;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] alu_R;
  logic        stall;
  logic [31:0] A, B;
  logic [2:0]  ALUControl;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        illegal;

  logic        alu_en;
  logic [31:0] alu_R_dir;
  logic [31:0] alu_R_model;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the instruction currently presented to the ALU.
  logic        m_valid;
  logic [2:0]  m_ctrl;
  logic [4:0]  m_rd;
  logic        m_ill;
  logic [31:0] m_A, m_B;
  logic [31:0] m_prev_res;

  alu_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_R(alu_R), .stall(stall), .A(A), .B(B), .ALUControl(ALUControl),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU: R is registered one edge after A/B/ALUControl.
  always @(posedge clk) alu_R_model <= alu_f(ALUControl, A, B);
  assign alu_R = alu_en ? alu_R_model : alu_R_dir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                       input logic [15:0] imm);
    in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_rs_val = rsv; in_rt_val = rtv; in_imm = imm;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0);
  endtask

  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf_val);
    if (idx == 5'd0) return 32'd0;
    if (m_valid && !m_ill && m_rd == idx) return m_prev_res;
    if (wb_valid && wb_rd == idx) return wb_data;
    return rf_val;
  endfunction

  initial begin
    reset = 1'b0; stall = 1'b0; alu_en = 1'b0; alu_R_dir = 32'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ctrl", 32'(ALUControl), 32'h7);
    check("rst_A", A, 32'd0);
    check("rst_B", B, 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // ADD r3 = r1 + r2, then dependent SUB r4 = r3 - r1
    @(negedge clk); reset = 1'b1;
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
    @(negedge clk);
    drive(1'b1, 3'b001, 5'd3, 5'd1, 5'd4, 32'd99, 32'd5, 16'd0);
    #1;
    check("add_A", A, 32'd5);
    check("add_B", B, 32'd7);
    check("add_ctrl", 32'(ALUControl), 32'h0);
    check("add_ex_rd", 32'(ex_rd), 32'd3);
    @(negedge clk); alu_R_dir = 32'd12; idle();
    #1;
    check("fwd_A", A, 32'd12);
    check("fwd_B", B, 32'd5);
    check("fwd_ctrl", 32'(ALUControl), 32'h1);
    @(negedge clk);
    #1;
    check("drain_valid", 32'(ex_valid), 32'd0);
    check("drain_A", A, 32'd0);
    check("drain_ctrl", 32'(ALUControl), 32'h7);

    // Stall while idle has no effect; then forwarding under a 2-cycle stall
    stall = 1'b1;
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
    #1;
    check("idle_stall_ready", 32'(in_ready), 32'd1);
    @(negedge clk); stall = 1'b0;
    drive(1'b1, 3'b001, 5'd3, 5'd1, 5'd4, 32'd99, 32'd5, 16'd0);
    #1;
    check("stall_add_A", A, 32'd5);
    @(negedge clk); alu_R_dir = 32'd12; stall = 1'b1; idle();
    #1;
    check("stall0_A", A, 32'd12);
    check("stall0_ready", 32'(in_ready), 32'd0);
    @(negedge clk); alu_R_dir = 32'd7;
    #1;
    check("stall1_A", A, 32'd12);
    check("stall1_B", B, 32'd5);
    check("stall1_ctrl", 32'(ALUControl), 32'h1);
    check("stall1_ready", 32'(in_ready), 32'd0);
    @(negedge clk); alu_R_dir = 32'd3; stall = 1'b0;
    #1;
    check("stall2_A", A, 32'd12);
    check("stall2_valid", 32'(ex_valid), 32'd1);
    check("stall2_ready", 32'(in_ready), 32'd1);

    // Immediate: rt matches the in-flight rd but B is never forwarded
    @(negedge clk);
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 16'd0);
    @(negedge clk);
    drive(1'b1, 3'b011, 5'd1, 5'd7, 5'd5, 32'd10, 32'h33, 16'hFFFC);
    @(negedge clk); alu_R_dir = 32'h1234; idle();
    #1;
    check("imm_A", A, 32'd10);
    check("imm_B", B, 32'hFFFFFFFC);
    check("imm_ctrl", 32'(ALUControl), 32'h0);
    check("imm_ex_rd", 32'(ex_rd), 32'd5);

    // r0 destination held, then XOR with rs=r0 and a writeback hit on rt
    @(negedge clk);
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 16'd0);
    @(negedge clk);
    drive(1'b1, 3'b010, 5'd0, 5'd6, 5'd8, 32'hDEAD, 32'd1, 16'd0);
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h55;
    #1;
    check("r0_ex_rd", 32'(ex_rd), 32'd0);
    check("r0_valid", 32'(ex_valid), 32'd1);
    @(negedge clk); alu_R_dir = 32'hAAAA; wb_valid = 1'b0;
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
    #1;
    check("wb_A", A, 32'd0);
    check("wb_B", B, 32'h55);
    check("wb_ctrl", 32'(ALUControl), 32'h2);

    // Forward beats writeback for the same register
    @(negedge clk);
    drive(1'b1, 3'b001, 5'd3, 5'd1, 5'd4, 32'd99, 32'd5, 16'd0);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h44;
    @(negedge clk); alu_R_dir = 32'd12; wb_valid = 1'b0;
    drive(1'b1, 3'b110, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 16'd0);
    #1;
    check("prio_A", A, 32'd12);

    // Illegal op, then ADD reading its rd
    @(negedge clk); alu_R_dir = 32'h99999;
    drive(1'b1, 3'b000, 5'd9, 5'd0, 5'd10, 32'h77, 32'h88, 16'd0);
    #1;
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_ctrl", 32'(ALUControl), 32'h7);
    check("ill_ex_rd", 32'(ex_rd), 32'd0);
    @(negedge clk); alu_R_dir = 32'd0; idle();
    #1;
    check("post_ill_A", A, 32'h77);
    check("post_ill_B", B, 32'd0);
    check("post_ill_flag", 32'(illegal), 32'd0);

    // Asynchronous reset in the middle of a stall
    @(negedge clk);
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
    @(negedge clk); stall = 1'b1; idle();
    #1;
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    @(negedge clk); #2 reset = 1'b0; #1;
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_ctrl", 32'(ALUControl), 32'h7);
    check("arst_A", A, 32'd0);
    check("arst_B", B, 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    @(negedge clk); reset = 1'b1; stall = 1'b0;

    // Randomized traffic against the reference model with a live ALU
    alu_en = 1'b1;
    m_valid = 1'b0; m_ctrl = 3'h7; m_rd = 5'd0; m_ill = 1'b0; m_A = 32'd0; m_B = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check("rnd_valid", 32'(ex_valid), 32'(m_valid));
      check("rnd_ctrl", 32'(ALUControl), m_valid ? 32'(m_ctrl) : 32'h7);
      check("rnd_ex_rd", 32'(ex_rd), m_valid ? 32'(m_rd) : 32'd0);
      check("rnd_illegal", 32'(illegal), 32'(m_valid && m_ill));
      check("rnd_A", A, m_valid ? m_A : 32'd0);
      check("rnd_B", B, m_valid ? m_B : 32'd0);
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom, 16'($urandom));
      wb_valid = 1'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 3));
      wb_data  = $urandom;
      stall    = ($urandom_range(0, 3) == 0);
      #1;
      check("rnd_ready", 32'(in_ready), 32'(!(m_valid && stall)));
      if (in_valid && !(m_valid && stall)) begin
        logic [31:0] na, nb;
        m_prev_res = alu_f(m_ctrl, m_A, m_B);
        na = resolve(in_rs, in_rs_val);
        if (in_op == 3'd3 || in_op == 3'd4) nb = {{16{in_imm[15]}}, in_imm};
        else nb = resolve(in_rt, in_rt_val);
        m_A = na; m_B = nb; m_valid = 1'b1;
        m_ill = (in_op > 3'd4);
        m_rd  = m_ill ? 5'd0 : in_rd;
        case (in_op)
          3'd0, 3'd3: m_ctrl = 3'h0;
          3'd1:       m_ctrl = 3'h1;
          3'd2, 3'd4: m_ctrl = 3'h2;
          default:    m_ctrl = 3'h7;
        endcase
      end else if (!stall) begin
        m_valid = 1'b0; m_ctrl = 3'h7; m_rd = 5'd0; m_ill = 1'b0; m_A = 32'd0; m_B = 32'd0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
